axil_led_pwm_timer: RTL and testbench
=====================================

// Module: axil_led_pwm_timer
// PURPOSE
//  AXI4-Lite slave peripheral on the Sapphire SoC's user AXI4-Lite master port.
//  Provides software-controlled LED outputs (direct or PWM-dimmed) and a periodic timer.
//  The timer drives the SoC's userInterruptA input.
//  Everything is clocked on the SoC system clock and reset by the SoC system reset output.
// PARAMETERS
//  ADDR_WIDTH  8   byte-address width of the AXI4-Lite slave; only bits [4:2] are decoded.
//  NUM_LEDS    4   number of LED outputs (1..32).
//  CNT_WIDTH   32  width of the timer counter and of the PERIOD and DUTY registers (1..32).
// PORTS
//  io_systemClk     in   1           system clock; all logic is on its rising edge.
//  io_systemReset   in   1           asynchronous, active-high reset.
//  axi_awvalid      in   1           write-address valid.
//  axi_awready      out  1           write-address ready.
//  axi_awaddr       in   ADDR_WIDTH  write byte address.
//  axi_wvalid       in   1           write-data valid.
//  axi_wready       out  1           write-data ready.
//  axi_wdata        in   32          write data.
//  axi_wstrb        in   4           byte strobes; a register byte is updated only when its strobe is 1.
//  axi_bvalid       out  1           write-response valid.
//  axi_bready       in   1           write-response ready.
//  axi_bresp        out  2           write response: 2'b00 OKAY, 2'b10 SLVERR.
//  axi_arvalid      in   1           read-address valid.
//  axi_arready      out  1           read-address ready.
//  axi_araddr       in   ADDR_WIDTH  read byte address.
//  axi_rvalid       out  1           read-data valid.
//  axi_rready       in   1           read-data ready.
//  axi_rdata        out  32          read data.
//  axi_rresp        out  2           read response: OKAY or SLVERR.
//  leds             out  NUM_LEDS    LED drive outputs.
//  userInterruptA   out  1           level interrupt to the SoC.
// BEHAVIOUR
//  Register map (word address = addr[4:2]):
//   0x00 CTRL     RW  bit0 EN, bit1 IRQ_EN, bit2 PWM_MODE.
//   0x04 LED      RW  bits[NUM_LEDS-1:0] LED pattern.
//   0x08 PERIOD   RW  timer period.
//   0x0C DUTY     RW  PWM on-count.
//   0x10 STATUS   W1C bit0 WRAP_PEND.
//   0x14 COUNT    RO  current counter value.
//   0x18-0x1C unmapped: response SLVERR, reads return 0, writes have no effect.
//   Unused register bits read as 0.
//  Reset values: all registers = 0, counter = 0, every AXI valid/ready = 0,
//   bresp = rresp = 0, rdata = 0, leds = 0, userInterruptA = 0.
//  Write channel:
//   - A write is accepted only in the cycle where awvalid & wvalid & !bvalid.
//   - In that cycle awready and wready pulse high together for exactly 1 cycle.
//   - The register updates at the end of that cycle.
//   - bvalid rises the next cycle and holds, with bresp stable, until bready.
//   - AW without W, or W without AW, is never accepted alone: both wait.
//  Read channel:
//   - arready pulses high for 1 cycle when arvalid & !rvalid.
//   - rdata/rresp are captured at the end of that cycle; rvalid rises the next cycle
//     and holds, with rdata stable, until rready.
//   - Read and write channels are independent and may complete in the same cycle.
//  Timer:
//   - If EN=1 and PERIOD!=0: count increments by 1 per cycle. When count==PERIOD it
//     reloads 0 on the next edge and WRAP_PEND sets (full period = PERIOD+1 cycles).
//   - If EN=0 or PERIOD==0: count holds its value and WRAP_PEND never sets.
//   - Any accepted write to PERIOD clears count to 0 in the same edge.
//   - Clearing EN freezes count. Setting EN resumes counting from the frozen value.
//  WRAP_PEND:
//   - Writing 1 to STATUS bit0 clears it; writing 0 has no effect.
//   - If a W1C write and a wrap occur on the same edge, the set wins (WRAP_PEND=1).
//  userInterruptA = WRAP_PEND & IRQ_EN, registered; it is 1 cycle behind WRAP_PEND.
//  leds:
//   - PWM_MODE=0: leds = LED[NUM_LEDS-1:0].
//   - PWM_MODE=1: leds = (count < DUTY) ? LED : 0. If DUTY > PERIOD, leds = LED permanently.
//   - leds is registered: it updates 1 cycle after the count or register change.
//  Reset asserted mid-transaction: all state returns to reset values immediately;
//   the in-flight transaction is dropped and no response is issued.
// TESTING
//  1. Write LED=0x5, CTRL=0 -> after B handshake (bresp=00), leds=4'b0101 within 2 cycles.
//  2. PERIOD=9, CTRL=0x3 -> WRAP_PEND sets every 10 cycles; userInterruptA=1 one cycle
//     later; write STATUS=1 -> interrupt drops; it re-asserts at the next wrap.
//  3. PERIOD=3, DUTY=2, LED=0xF, CTRL=0x5 -> leds pattern F,F,0,0 repeating; DUTY=5 -> leds stay F.
//  4. Read 0x1C -> rresp=10, rdata=0; write 0x18 -> bresp=10, all registers unchanged.
//  5. Hold bready=0 after a write, then issue a 2nd write -> awready/wready stay 0 until the
//     1st B handshake; concurrent read of COUNT completes meanwhile.
//  6. Align a W1C write with the wrap edge -> WRAP_PEND=1. Assert io_systemReset during an
//     open R beat -> rvalid=0, all registers 0 on the next cycle.

Source files
------------

// File: rtl/axil_led_pwm_timer.sv
// AXI4-Lite slave providing direct or PWM-dimmed LED outputs and a periodic
// timer whose wrap event raises userInterruptA. All logic is on io_systemClk,
// asynchronously reset by io_systemReset (active high).
module axil_led_pwm_timer #(
    parameter int ADDR_WIDTH = 8,
    parameter int NUM_LEDS   = 4,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  io_systemClk,
    input  logic                  io_systemReset,
    input  logic                  axi_awvalid,
    output logic                  axi_awready,
    input  logic [ADDR_WIDTH-1:0] axi_awaddr,
    input  logic                  axi_wvalid,
    output logic                  axi_wready,
    input  logic [31:0]           axi_wdata,
    input  logic [3:0]            axi_wstrb,
    output logic                  axi_bvalid,
    input  logic                  axi_bready,
    output logic [1:0]            axi_bresp,
    input  logic                  axi_arvalid,
    output logic                  axi_arready,
    input  logic [ADDR_WIDTH-1:0] axi_araddr,
    output logic                  axi_rvalid,
    input  logic                  axi_rready,
    output logic [31:0]           axi_rdata,
    output logic [1:0]            axi_rresp,
    output logic [NUM_LEDS-1:0]   leds,
    output logic                  userInterruptA
);

    typedef enum logic [2:0] {
        REG_CTRL   = 3'd0,
        REG_LED    = 3'd1,
        REG_PERIOD = 3'd2,
        REG_DUTY   = 3'd3,
        REG_STATUS = 3'd4,
        REG_COUNT  = 3'd5,
        REG_RSVD6  = 3'd6,
        REG_RSVD7  = 3'd7
    } reg_sel_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    logic [2:0]           ctrl;       // {PWM_MODE, IRQ_EN, EN}
    logic [NUM_LEDS-1:0]  led_reg;
    logic [CNT_WIDTH-1:0] period;
    logic [CNT_WIDTH-1:0] duty;
    logic [CNT_WIDTH-1:0] count;
    logic                 wrap_pend;

    reg_sel_e    wr_sel;
    reg_sel_e    rd_sel;
    logic        wr_fire;
    logic        rd_fire;
    logic        running;
    logic        wrap;
    logic        wr_period;
    logic        w1c_pend;
    logic        pwm_on;
    logic        rd_err;
    logic [31:0] rd_value;
    logic        unused_addr_bits;

    // Byte-lane merge of write data into an existing 32-bit register image.
    function automatic logic [31:0] merge_strb(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  strb);
        logic [31:0] merged;
        merged = old_val;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) merged[8*b +: 8] = new_val[8*b +: 8];
        end
        return merged;
    endfunction

    assign wr_sel  = reg_sel_e'(axi_awaddr[4:2]);
    assign rd_sel  = reg_sel_e'(axi_araddr[4:2]);

    // A write needs both AW and W present and no response outstanding.
    assign axi_awready = axi_awvalid & axi_wvalid & ~axi_bvalid;
    assign axi_wready  = axi_awready;
    assign wr_fire     = axi_awready;
    assign axi_arready = axi_arvalid & ~axi_rvalid;
    assign rd_fire     = axi_arready;

    assign running   = ctrl[0] & (period != '0);
    assign wrap      = running & (count == period);
    assign wr_period = wr_fire & (wr_sel == REG_PERIOD);
    assign w1c_pend  = wr_fire & (wr_sel == REG_STATUS) & axi_wstrb[0] & axi_wdata[0];
    // DUTY above PERIOD can never be reached by count, so LEDs stay fully on.
    assign pwm_on    = (duty > period) | (count < duty);

    // Only addr[4:2] is decoded; the remaining address bits are don't-care.
    assign unused_addr_bits = ^{axi_awaddr, axi_araddr};

    // Read data mux, zero-extended to the 32-bit bus.
    always_comb begin
        // NOTE: defaults first so every path assigns every output -- no latches.
        rd_value = '0;
        rd_err   = 1'b0;
        case (rd_sel)
            REG_CTRL:   rd_value = 32'(ctrl);
            REG_LED:    rd_value = 32'(led_reg);
            REG_PERIOD: rd_value = 32'(period);
            REG_DUTY:   rd_value = 32'(duty);
            REG_STATUS: rd_value = 32'(wrap_pend);
            REG_COUNT:  rd_value = 32'(count);
            default:    rd_err   = 1'b1;
        endcase
    end

    // Software-visible control registers, updated on an accepted write.
    always_ff @(posedge io_systemClk or posedge io_systemReset) begin
        // NOTE: non-blocking (<=) on all state so every flop samples pre-edge values.
        if (io_systemReset) begin
            ctrl    <= '0;
            led_reg <= '0;
            period  <= '0;
            duty    <= '0;
        end else if (wr_fire) begin
            case (wr_sel)
                REG_CTRL:   ctrl    <= 3'(merge_strb(32'(ctrl), axi_wdata, axi_wstrb));
                REG_LED:    led_reg <= NUM_LEDS'(merge_strb(32'(led_reg), axi_wdata, axi_wstrb));
                REG_PERIOD: period  <= CNT_WIDTH'(merge_strb(32'(period), axi_wdata, axi_wstrb));
                REG_DUTY:   duty    <= CNT_WIDTH'(merge_strb(32'(duty), axi_wdata, axi_wstrb));
                default:    ;
            endcase
        end
    end

    // Timer counter: PERIOD write restarts it, wrap reloads 0, EN=0 freezes it.
    always_ff @(posedge io_systemClk or posedge io_systemReset) begin
        if (io_systemReset)  count <= '0;
        else if (wr_period)  count <= '0;
        else if (wrap)       count <= '0;
        else if (running)    count <= count + CNT_WIDTH'(1);
    end

    // Sticky wrap flag (set beats W1C), registered interrupt and LED drive.
    always_ff @(posedge io_systemClk or posedge io_systemReset) begin
        if (io_systemReset) begin
            wrap_pend      <= 1'b0;
            userInterruptA <= 1'b0;
            leds           <= '0;
        end else begin
            if (wrap)          wrap_pend <= 1'b1;
            else if (w1c_pend) wrap_pend <= 1'b0;
            userInterruptA <= wrap_pend & ctrl[1];
            leds           <= (~ctrl[2] | pwm_on) ? led_reg : '0;
        end
    end

    // Write response channel: raised after acceptance, held until bready.
    always_ff @(posedge io_systemClk or posedge io_systemReset) begin
        if (io_systemReset) begin
            axi_bvalid <= 1'b0;
            axi_bresp  <= RESP_OKAY;
        end else if (wr_fire) begin
            axi_bvalid <= 1'b1;
            axi_bresp  <= (wr_sel == REG_RSVD6 || wr_sel == REG_RSVD7) ? RESP_SLVERR : RESP_OKAY;
        end else if (axi_bready) begin
            axi_bvalid <= 1'b0;
        end
    end

    // Read data channel: data captured at address acceptance, held until rready.
    always_ff @(posedge io_systemClk or posedge io_systemReset) begin
        if (io_systemReset) begin
            axi_rvalid <= 1'b0;
            axi_rdata  <= '0;
            axi_rresp  <= RESP_OKAY;
        end else if (rd_fire) begin
            axi_rvalid <= 1'b1;
            axi_rdata  <= rd_value;
            axi_rresp  <= rd_err ? RESP_SLVERR : RESP_OKAY;
        end else if (axi_rready) begin
            axi_rvalid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_axil_led_pwm_timer.sv
// Self-checking bench for axil_led_pwm_timer: a register-level behavioural
// model is advanced every clock and compared against every DUT output each
// cycle; directed scenarios pin the model with hand-computed values, then a
// randomized phase exercises arbitrary handshake timing.
`timescale 1ns/1ps
module tb_axil_led_pwm_timer;

    localparam int ADDR_WIDTH = 8;
    localparam int NUM_LEDS   = 4;
    localparam int CNT_WIDTH  = 32;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 awvalid = 1'b0;
    logic                 awready;
    logic [7:0]           awaddr = '0;
    logic                 wvalid = 1'b0;
    logic                 wready;
    logic [31:0]          wdata = '0;
    logic [3:0]           wstrb = '0;
    logic                 bvalid;
    logic                 bready = 1'b0;
    logic [1:0]           bresp;
    logic                 arvalid = 1'b0;
    logic                 arready;
    logic [7:0]           araddr = '0;
    logic                 rvalid;
    logic                 rready = 1'b0;
    logic [31:0]          rdata;
    logic [1:0]           rresp;
    logic [NUM_LEDS-1:0]  leds;
    logic                 irq;

    axil_led_pwm_timer #(
        .ADDR_WIDTH(ADDR_WIDTH), .NUM_LEDS(NUM_LEDS), .CNT_WIDTH(CNT_WIDTH)
    ) dut (
        .io_systemClk(clk), .io_systemReset(rst),
        .axi_awvalid(awvalid), .axi_awready(awready), .axi_awaddr(awaddr),
        .axi_wvalid(wvalid), .axi_wready(wready), .axi_wdata(wdata), .axi_wstrb(wstrb),
        .axi_bvalid(bvalid), .axi_bready(bready), .axi_bresp(bresp),
        .axi_arvalid(arvalid), .axi_arready(arready), .axi_araddr(araddr),
        .axi_rvalid(rvalid), .axi_rready(rready), .axi_rdata(rdata), .axi_rresp(rresp),
        .leds(leds), .userInterruptA(irq)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    // Behavioural model: register file indexed by word address, plain integers.
    logic [31:0]         m_reg [0:3];   // CTRL, LED, PERIOD, DUTY
    longint unsigned     m_count;
    bit                  m_pend, m_irq, m_bvalid, m_rvalid, m_wr_acc, m_rd_acc;
    logic [1:0]          m_bresp, m_rresp;
    logic [31:0]         m_rdata;
    logic [NUM_LEDS-1:0] m_leds;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h, required %0h", name, $time, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s @%0t: timed out waiting for handshake", name, $time);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_reg[i] = '0;
        m_count = 0; m_pend = 0; m_irq = 0; m_bvalid = 0; m_rvalid = 0;
        m_wr_acc = 0; m_rd_acc = 0; m_bresp = '0; m_rresp = '0; m_rdata = '0; m_leds = '0;
    endtask

    function automatic logic [31:0] model_read(input logic [2:0] a);
        case (a)
            3'd0, 3'd1, 3'd2, 3'd3: return m_reg[a[1:0]];
            3'd4:                   return 32'(m_pend);
            3'd5:                   return m_count[31:0];
            default:                return '0;
        endcase
    endfunction

    // Advance the model over one rising edge using the inputs the bench is driving.
    task automatic model_update();
        bit wr, rd, running, wrap;
        logic [2:0] wa, ra;
        longint unsigned per;
        if (rst) begin model_reset(); cyc++; return; end
        wr = awvalid && wvalid && !m_bvalid;
        rd = arvalid && !m_rvalid;
        wa = awaddr[4:2];
        ra = araddr[4:2];
        per = m_reg[2];
        running = m_reg[0][0] && per != 0;
        wrap = running && m_count == per;
        m_irq = m_pend && m_reg[0][1];
        if (!m_reg[0][2] || m_reg[3] > m_reg[2] || m_count < m_reg[3]) m_leds = m_reg[1][NUM_LEDS-1:0];
        else m_leds = '0;
        if (rd) begin
            m_rdata = model_read(ra);
            m_rresp = (ra >= 3'd6) ? 2'b10 : 2'b00;
        end
        m_rvalid = rd || (m_rvalid && !rready);
        if (wr && wa == 3'd2) m_count = 0;
        else if (running)     m_count = (m_count + 1) % (per + 1);
        if (wrap) m_pend = 1;
        else if (wr && wa == 3'd4 && wstrb[0] && wdata[0]) m_pend = 0;
        if (wr && wa < 3'd4) begin
            for (int b = 0; b < 4; b++)
                if (wstrb[b]) m_reg[wa[1:0]][8*b +: 8] = wdata[8*b +: 8];
            m_reg[0] = 32'(m_reg[0][2:0]);
            m_reg[1] = 32'(m_reg[1][NUM_LEDS-1:0]);
        end
        if (wr) m_bresp = (wa >= 3'd6) ? 2'b10 : 2'b00;
        m_bvalid = wr || (m_bvalid && !bready);
        m_wr_acc = wr;
        m_rd_acc = rd;
        cyc++;
    endtask

    // One clock: check combinational readies, update model at the edge,
    // then compare all registered outputs on the falling edge.
    task automatic tick();
        #1;
        if (!rst) begin
            check("awready", awready, awvalid && wvalid && !m_bvalid);
            check("wready",  wready,  awvalid && wvalid && !m_bvalid);
            check("arready", arready, arvalid && !m_rvalid);
        end
        @(posedge clk);
        model_update();
        @(negedge clk);
        check("bvalid", bvalid, m_bvalid);
        check("bresp",  bresp,  m_bresp);
        check("rvalid", rvalid, m_rvalid);
        check("rdata",  rdata,  m_rdata);
        check("rresp",  rresp,  m_rresp);
        check("leds",   leds,   m_leds);
        check("irq",    irq,    m_irq);
    endtask

    task automatic axi_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] resp);
        int n;
        awaddr = a; wdata = d; wstrb = s; awvalid = 1; wvalid = 1; bready = 1;
        tick(); n = 1;
        while (!m_wr_acc && n < 20) begin tick(); n++; end
        awvalid = 0; wvalid = 0;
        if (!m_wr_acc) begin timeout_fail("write_accept"); resp = 2'b11; return; end
        resp = bresp;
        n = 0;
        while (m_bvalid && n < 20) begin tick(); n++; end
    endtask

    task automatic wr32(input logic [7:0] a, input logic [31:0] d);
        logic [1:0] r;
        axi_write(a, d, 4'hF, r);
        check("bresp_okay", r, 2'b00);
    endtask

    task automatic axi_read(input logic [7:0] a, output logic [31:0] d, output logic [1:0] resp);
        int n;
        araddr = a; arvalid = 1; rready = 1;
        tick(); n = 1;
        while (!m_rd_acc && n < 20) begin tick(); n++; end
        arvalid = 0;
        if (!m_rd_acc) begin timeout_fail("read_accept"); d = '0; resp = 2'b11; return; end
        d = rdata; resp = rresp;
        tick();
    endtask

    task automatic wait_rise(input int limit, output bit ok);
        bit prev;
        prev = irq; ok = 0;
        for (int i = 0; i < limit; i++) begin
            tick();
            if (!prev && irq) begin ok = 1; break; end
            prev = irq;
        end
    endtask

    task automatic wait_count(input longint unsigned v, input string name);
        int n;
        n = 0;
        while (m_count != v && n < 40) begin tick(); n++; end
        if (m_count != v) timeout_fail(name);
    endtask

    initial begin
        logic [31:0] d;
        logic [1:0]  r;
        int          n, t1, nf, nz;
        bit          ok, saw_ready, saw_rvalid, wpend, w_on, rpend;

        model_reset();
        repeat (3) tick();
        check("reset_leds", leds, 4'h0);
        check("reset_irq", irq, 1'b0);
        check("reset_bvalid", bvalid, 1'b0);
        check("reset_rvalid", rvalid, 1'b0);
        rst = 0;
        tick();

        // Direct LED drive.
        wr32(8'h04, 32'h5);
        wr32(8'h00, 32'h0);
        tick(); tick();
        check("led_direct", leds, 4'b0101);

        // Periodic interrupt, W1C and re-assertion.
        wr32(8'h08, 32'd9);
        wr32(8'h00, 32'h3);
        wait_rise(40, ok);
        check("irq_first_rise", ok, 1'b1);
        t1 = cyc;
        wr32(8'h10, 32'h1);
        check("irq_cleared", irq, 1'b0);
        wait_rise(20, ok);
        check("irq_rerise", ok, 1'b1);
        check("irq_period_cycles", cyc - t1, 10);

        // PWM: PERIOD=3, DUTY=2 -> two of every four cycles on.
        wr32(8'h08, 32'd3);
        wr32(8'h0C, 32'd2);
        wr32(8'h04, 32'hF);
        wr32(8'h00, 32'h5);
        nf = 0; nz = 0;
        repeat (8) begin
            tick();
            if (leds == 4'hF) nf++;
            if (leds == 4'h0) nz++;
        end
        check("pwm_on_samples", nf, 4);
        check("pwm_off_samples", nz, 4);
        wr32(8'h0C, 32'd5);
        tick(); tick();
        nf = 0;
        repeat (8) begin tick(); if (leds == 4'hF) nf++; end
        check("pwm_duty_over_period", nf, 8);

        // Unmapped space.
        axi_read(8'h1C, d, r);
        check("unmapped_rresp", r, 2'b10);
        check("unmapped_rdata", d, 32'h0);
        axi_write(8'h18, 32'hFFFF_FFFF, 4'hF, r);
        check("unmapped_bresp", r, 2'b10);
        axi_read(8'h04, d, r);
        check("led_kept", d, 32'hF);
        axi_read(8'h08, d, r);
        check("period_kept", d, 32'd3);
        axi_read(8'h00, d, r);
        check("ctrl_kept", d, 32'h5);

        // Back-pressured B blocks a second write while a read completes.
        bready = 0; awaddr = 8'h04; wdata = 32'h3; wstrb = 4'hF; awvalid = 1; wvalid = 1;
        tick(); n = 1;
        while (!m_wr_acc && n < 20) begin tick(); n++; end
        if (!m_wr_acc) timeout_fail("bp_first_accept");
        wdata = 32'h6; araddr = 8'h14; arvalid = 1; rready = 1;
        saw_ready = 0; saw_rvalid = 0;
        repeat (6) begin
            tick();
            if (awready || wready) saw_ready = 1;
            if (rvalid) saw_rvalid = 1;
            if (m_rd_acc) arvalid = 0;
        end
        arvalid = 0;
        check("bp_no_second_accept", saw_ready, 1'b0);
        check("bp_read_completed", saw_rvalid, 1'b1);
        bready = 1;
        tick(); n = 1;
        while (!m_wr_acc && n < 20) begin tick(); n++; end
        awvalid = 0; wvalid = 0;
        if (!m_wr_acc) timeout_fail("bp_second_accept");
        tick();
        axi_read(8'h04, d, r);
        check("bp_second_write", d, 32'h6);

        // W1C on the wrap edge: the set wins.
        wr32(8'h08, 32'd9);
        wr32(8'h00, 32'h1);
        wait_count(4, "align_clear_wait");
        wr32(8'h10, 32'h1);
        wait_count(9, "align_wrap_wait");
        awaddr = 8'h10; wdata = 32'h1; wstrb = 4'h1; awvalid = 1; wvalid = 1; bready = 1;
        tick();
        check("w1c_aligned_accept", m_wr_acc, 1'b1);
        awvalid = 0; wvalid = 0;
        tick();
        axi_read(8'h10, d, r);
        check("w1c_vs_wrap", d, 32'h1);
        wr32(8'h00, 32'h0);
        wr32(8'h10, 32'h1);
        axi_read(8'h10, d, r);
        check("w1c_clears", d, 32'h0);

        // Reset while an R beat is open.
        rready = 0; araddr = 8'h00; arvalid = 1;
        tick(); n = 1;
        while (!m_rd_acc && n < 20) begin tick(); n++; end
        arvalid = 0;
        check("open_r_beat", rvalid, 1'b1);
        rst = 1;
        model_reset();
        #1;
        check("rst_rvalid", rvalid, 1'b0);
        check("rst_leds", leds, 4'h0);
        check("rst_irq", irq, 1'b0);
        tick(); tick();
        rst = 0; rready = 1;
        axi_read(8'h04, d, r);
        check("rst_led_reg", d, 32'h0);
        axi_read(8'h08, d, r);
        check("rst_period_reg", d, 32'h0);

        // Randomized traffic with arbitrary handshake timing.
        wpend = 0; w_on = 0; rpend = 0;
        for (int c = 0; c < 4000; c++) begin
            if (m_wr_acc) begin wpend = 0; w_on = 0; end
            if (m_rd_acc) rpend = 0;
            if (!wpend && $urandom_range(0, 3) == 0) begin
                wpend = 1;
                awaddr = 8'($urandom);
                case (awaddr[4:2])
                    3'd0:    wdata = 32'($urandom_range(0, 7));
                    3'd2:    wdata = 32'($urandom_range(0, 12));
                    3'd3:    wdata = 32'($urandom_range(0, 14));
                    default: wdata = $urandom;
                endcase
                wstrb = ($urandom_range(0, 3) != 0) ? 4'hF : 4'($urandom_range(0, 15));
            end
            if (wpend && $urandom_range(0, 2) != 0) w_on = 1;
            awvalid = wpend;
            wvalid  = wpend && w_on;
            bready  = $urandom_range(0, 2) != 0;
            if (!rpend && $urandom_range(0, 3) == 0) begin
                rpend = 1;
                araddr = 8'($urandom);
            end
            arvalid = rpend;
            rready  = $urandom_range(0, 2) != 0;
            tick();
        end
        awvalid = 0; wvalid = 0; arvalid = 0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
